neuron_mac_ctrl: RTL and testbench
==================================

# neuron_mac_ctrl

Sequencer for one fully-connected neuron evaluation. It accepts a stream of N_IN signed activation/weight pairs, multiplies each pair and accumulates the products. It then adds a bias, optionally applies ReLU, and rescales and saturates the result to the output width. It sits between the activation/weight buffers (the demultiplexer/multiplexer stages) and the next layer's input register, and owns the enable and valid sequencing for that multiply/add/ReLU datapath.

## Interface
- I_WIDTH, 8, width of the signed activation and weight inputs.
- ACC_WIDTH, 24, width of the signed accumulator and bias. Must be ≥ 2*I_WIDTH + $clog2(N_IN) + 1.
- N_IN, 16, number of input pairs per neuron. Must be ≥ 1.
- O_WIDTH, 8, width of the signed result.
- FRAC, 0, arithmetic right shift applied before saturation.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  pulse that begins one neuron evaluation. Ignored while busy.
- bias  in  ACC_WIDTH  signed bias, sampled on an accepted start.
- relu_en  in  1  sampled on an accepted start. 1 = apply ReLU, 0 = bypass.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  x/w pair present.
- in_ready  out  1  controller can accept a pair.
- x  in  I_WIDTH  signed activation.
- w  in  I_WIDTH  signed weight.
- out_valid  out  1  y is valid.
- out_ready  in  1  consumer accepts y.
- y  out  O_WIDTH  signed result.
- idx  out  $clog2(N_IN) (min 1)  index of the next pair expected, for buffer addressing.

## Operation
- The state machine has four states: IDLE, ACCUM, BIAS, OUT.
- IDLE:
  - start=1 → acc<=0, cnt<=0, latch bias and relu_en, next state ACCUM.
- ACCUM:
  - in_ready=1.
  - A pair is accepted on a cycle where in_valid && in_ready: acc <= acc + sext(x*w), cnt <= cnt+1.
  - On acceptance of the pair with cnt==N_IN-1, next state is BIAS.
  - in_valid low inserts a bubble: no change to acc or cnt.
- BIAS:
  - acc <= acc + bias_q, next state OUT.
  - In the same transition, y is registered from the post-bias value:
    - r = (relu_en_q && v<0) ? 0 : v, where v = acc+bias_q;
    - s = r >>> FRAC (arithmetic shift);
    - y = s clamped to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1].
- OUT:
  - out_valid=1; y held stable.
  - out_valid && out_ready → next state IDLE, out_valid drops the following cycle.
- Arithmetic:
  - Products are full 2*I_WIDTH signed, sign-extended to ACC_WIDTH.
  - The accumulator wraps in two's complement; the parameter constraint rules out overflow.
- idx equals cnt in ACCUM and is 0 elsewhere.
- start is ignored in ACCUM, BIAS and OUT, including the cycle out_ready is accepted. There is no back-to-back start in the IDLE-exit cycle: a new start is honoured only when the state is IDLE.

## Timing
- Reset values (rst=1 at a rising edge, from any state, including mid-ACCUM or OUT):
  - state IDLE;
  - acc, cnt, y = 0;
  - busy, in_ready, out_valid = 0.
  - No partial result is ever presented after reset.
- in_ready, busy and out_valid are decoded from the registered state. They have no combinational path from inputs.
- Latency, with start accepted at edge 0 and in_valid continuously high:
  - ACCUM spans cycles 1..N_IN;
  - BIAS is cycle N_IN+1;
  - out_valid is high from cycle N_IN+2.
  - Minimum total is N_IN+3 cycles, start to IDLE, when out_ready=1.
- Each in_valid bubble adds exactly one cycle.
- Each cycle with out_valid=1 and out_ready=0 adds one cycle. y, idx and out_valid are held unchanged during these cycles.
- in_valid and x/w are ignored outside ACCUM.
- Simultaneous rst and start: rst wins, and the state remains IDLE.

## Test plan
- N_IN=4, FRAC=0, relu_en=1, bias=0:
  - stimulus x=[1,2,3,4], w=[1,1,1,1] with in_valid high;
  - required: out_valid rises at cycle 6, y=10, busy low at cycle 7.
- Negative result:
  - stimulus x=[-1,-2,-3,-4], w=1, bias=0;
  - required: relu_en=1 → y=0; relu_en=0 → y=-10 (8'hF6).
- Saturation and shift:
  - stimulus x=w=127 for all 4 pairs (acc=64516), FRAC=0 → y=127;
  - stimulus x=-128, w=127 → y=-128;
  - stimulus x=[1,2,3,4], w=1, bias=6, FRAC=2 → y=4.
- Handshake stress:
  - stimulus: in_valid toggles 1,0,1,0,… and out_ready is held low for 3 cycles;
  - required: y is correct (10); completion is delayed by exactly the bubble and stall count; y and out_valid are stable while stalled; a start asserted in OUT has no effect.
- Reset mid-operation:
  - stimulus: rst pulsed after 2 accepted pairs, then a fresh start with x=[5,5,5,5], w=1;
  - required: y=20 with no contamination from the first run; all outputs are 0 in the cycle after rst.
- idx sequence:
  - required: idx reads 0,1,2,3 on the successive accepted beats and 0 in IDLE, BIAS and OUT.

Source files
------------

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: start/bias, pair stream and result handshake bundle for neuron_mac_ctrl
interface neuron_mac_if #(
    parameter int I_WIDTH   = 8,
    parameter int ACC_WIDTH = 24,
    parameter int O_WIDTH   = 8,
    parameter int N_IN      = 16
);
    localparam int IDX_W = N_IN > 1 ? $clog2(N_IN) : 1;
    logic                        start;
    logic signed [ACC_WIDTH-1:0] bias;
    logic                        relu_en;
    logic                        busy;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [I_WIDTH-1:0]   x;
    logic signed [I_WIDTH-1:0]   w;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [O_WIDTH-1:0]   y;
    logic [IDX_W-1:0]            idx;
    modport master (
        output start, bias, relu_en, in_valid, x, w, out_ready,
        input  busy, in_ready, out_valid, y, idx
    );
    modport slave (
        input  start, bias, relu_en, in_valid, x, w, out_ready,
        output busy, in_ready, out_valid, y, idx
    );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: sequences multiply-accumulate, bias, ReLU and saturation for one neuron
module neuron_mac_ctrl #(
    parameter int I_WIDTH   = 8,
    parameter int ACC_WIDTH = 24,
    parameter int N_IN      = 16,
    parameter int O_WIDTH   = 8,
    parameter int FRAC      = 0
) (
    input logic         clk,
    input logic         rst,
    neuron_mac_if.slave m
);
    localparam int IDX_W = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((longint'(1) << (O_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN = -Y_MAX - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, bias_q, sum, rect, shifted;
    logic signed [2*I_WIDTH-1:0] prod;
    logic [IDX_W-1:0]            cnt_q;
    logic                        relu_q, accept, last;
    logic [O_WIDTH-1:0]          y_q, y_sat;

    // post-bias result path: ReLU, arithmetic rescale, clamp to the output range
    always_comb begin
        prod    = m.x * m.w;
        sum     = acc_q + bias_q;
        rect    = (relu_q && sum[ACC_WIDTH-1]) ? '0 : sum;
        shifted = rect >>> FRAC;
        y_sat   = shifted > Y_MAX ? Y_MAX[O_WIDTH-1:0] :
                  shifted < Y_MIN ? Y_MIN[O_WIDTH-1:0] : shifted[O_WIDTH-1:0];
    end

    // next state and state-decoded handshake outputs
    always_comb begin
        accept      = state_q == ACCUM && m.in_valid;
        last        = cnt_q == IDX_W'(N_IN - 1);
        m.busy      = state_q != IDLE;
        m.in_ready  = state_q == ACCUM;
        m.out_valid = state_q == OUT;
        m.idx       = state_q == ACCUM ? cnt_q : '0;
        m.y         = y_q;
        state_d     = state_q == IDLE  ? (m.start ? ACCUM : IDLE) :
                      state_q == ACCUM ? (accept && last ? BIAS : ACCUM) :
                      state_q == BIAS  ? OUT :
                      (m.out_ready ? IDLE : OUT);
    end

    // state register
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    // accumulator, pair counter, latched per-neuron config and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            bias_q <= '0;
            relu_q <= 1'b0;
            y_q    <= '0;
        end else begin
            if (state_q == IDLE && m.start) begin
                acc_q  <= '0;
                cnt_q  <= '0;
                bias_q <= m.bias;
                relu_q <= m.relu_en;
            end
            if (accept) begin
                acc_q <= acc_q + ACC_WIDTH'(prod);
                cnt_q <= cnt_q + IDX_W'(1);
            end
            if (state_q == BIAS) begin
                acc_q <= sum;
                y_q   <= y_sat;
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// tb_neuron_mac_ctrl: directed and randomized checks of neuron_mac_ctrl against an arithmetic model
module tb_neuron_mac_ctrl;
    localparam int N  = 4;
    localparam int IW = 8;
    localparam int AW = 24;
    localparam int OW = 8;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic                 start = 0, relu_en = 0, in_valid = 0, out_ready = 0;
    logic signed [AW-1:0] bias = '0;
    logic signed [IW-1:0] x = '0, w = '0;

    neuron_mac_if #(.I_WIDTH(IW), .ACC_WIDTH(AW), .O_WIDTH(OW), .N_IN(N)) b0 ();
    neuron_mac_if #(.I_WIDTH(IW), .ACC_WIDTH(AW), .O_WIDTH(OW), .N_IN(N)) b1 ();

    assign b0.start = start;       assign b1.start = start;
    assign b0.bias = bias;         assign b1.bias = bias;
    assign b0.relu_en = relu_en;   assign b1.relu_en = relu_en;
    assign b0.in_valid = in_valid; assign b1.in_valid = in_valid;
    assign b0.x = x;               assign b1.x = x;
    assign b0.w = w;               assign b1.w = w;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;

    neuron_mac_ctrl #(.I_WIDTH(IW), .ACC_WIDTH(AW), .N_IN(N), .O_WIDTH(OW), .FRAC(0))
        u0 (.clk(clk), .rst(rst), .m(b0.slave));
    neuron_mac_ctrl #(.I_WIDTH(IW), .ACC_WIDTH(AW), .N_IN(N), .O_WIDTH(OW), .FRAC(2))
        u1 (.clk(clk), .rst(rst), .m(b1.slave));

    int checks = 0;
    int failures = 0;
    int xa[N];
    int wa[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [OW-1:0] model(input int b, input bit relu, input int frac);
        longint v = b;
        for (int i = 0; i < N; i++) v += longint'(xa[i]) * longint'(wa[i]);
        if (relu && v < 0) v = 0;
        v = v >>> frac;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return OW'(v);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(b0.busy), 0);
        chk({tag, "_in_ready"}, 32'(b0.in_ready), 0);
        chk({tag, "_out_valid"}, 32'(b0.out_valid), 0);
        chk({tag, "_idx"}, 32'(b0.idx), 0);
        chk({tag, "_y0"}, 32'(b0.y), 0);
        chk({tag, "_y1"}, 32'(b1.y), 0);
    endtask

    // mode: 0 in_valid always high, 1 toggles starting high, 2 random
    task automatic run(input int b, input bit relu, input int mode, input int stall);
        int k = 0;
        int cyc = 0;
        bit v;
        logic signed [OW-1:0] e0, e1;
        e0 = model(b, relu, 0);
        e1 = model(b, relu, 2);
        start = 1; bias = AW'(b); relu_en = relu; in_valid = 0; out_ready = 0;
        tick;
        start = 0;
        while (k < N) begin
            cyc++;
            v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 1) : ($urandom_range(0, 1) == 1);
            in_valid = v;
            x = v ? IW'(xa[k]) : IW'(rnd8());
            w = v ? IW'(wa[k]) : IW'(rnd8());
            chk("acc_busy", 32'(b0.busy), 1);
            chk("acc_in_ready", 32'(b0.in_ready), 1);
            chk("acc_out_valid", 32'(b0.out_valid), 0);
            chk("acc_idx", 32'(b0.idx), 32'(k));
            tick;
            if (v) k++;
        end
        in_valid = 1; x = IW'(rnd8()); w = IW'(rnd8());
        chk("bias_busy", 32'(b0.busy), 1);
        chk("bias_in_ready", 32'(b0.in_ready), 0);
        chk("bias_out_valid", 32'(b0.out_valid), 0);
        chk("bias_idx", 32'(b0.idx), 0);
        tick;
        start = 1;
        for (int s = 0; s <= stall; s++) begin
            chk("out_valid", 32'(b0.out_valid), 1);
            chk("out_in_ready", 32'(b0.in_ready), 0);
            chk("out_idx", 32'(b0.idx), 0);
            chk("y_frac0", 32'(b0.y), 32'(e0));
            chk("y_frac2", 32'(b1.y), 32'(e1));
            out_ready = s == stall;
            tick;
        end
        start = 0; out_ready = 0; in_valid = 0;
        chk("done_busy", 32'(b0.busy), 0);
        chk("done_out_valid", 32'(b0.out_valid), 0);
        chk("done_busy_frac2", 32'(b1.busy), 0);
        tick;
        chk("idle_busy", 32'(b0.busy), 0);
    endtask

    initial begin
        rst = 1;
        tick;
        tick;
        check_reset_outputs("reset");
        start = 1;
        tick;
        chk("rst_start_busy", 32'(b0.busy), 0);
        rst = 0; start = 0;
        tick;
        chk("post_rst_busy", 32'(b0.busy), 0);

        xa = '{1, 2, 3, 4};     wa = '{1, 1, 1, 1};
        run(0, 1, 0, 0);
        xa = '{-1, -2, -3, -4};
        run(0, 1, 0, 0);
        run(0, 0, 0, 0);
        xa = '{127, 127, 127, 127}; wa = '{127, 127, 127, 127};
        run(0, 0, 0, 0);
        xa = '{-128, -128, -128, -128};
        run(0, 0, 0, 0);
        xa = '{1, 2, 3, 4};     wa = '{1, 1, 1, 1};
        run(6, 1, 0, 0);
        run(0, 1, 1, 3);

        start = 1; bias = AW'(1000); relu_en = 0;
        tick;
        start = 0; in_valid = 1; x = 8'sd100; w = 8'sd100;
        tick;
        tick;
        chk("mid_idx", 32'(b0.idx), 2);
        rst = 1; in_valid = 0;
        tick;
        rst = 0;
        check_reset_outputs("mid_reset");
        xa = '{5, 5, 5, 5};     wa = '{1, 1, 1, 1};
        run(0, 1, 0, 0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < N; i++) begin
                xa[i] = rnd8();
                wa[i] = rnd8();
            end
            run(int'($urandom_range(0, 140000)) - 70000, 1'($urandom_range(0, 1)), 2,
                int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
